// File: rtl/bus_enable_ctrl.sv
// rtl/bus_enable_ctrl.sv - debounced push-button front end driving one-hot bus enables
module bus_enable_ctrl #(
  parameter int COUNT           = 4,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic [COUNT-1:0] btn_raw,
  output logic [COUNT-1:0] enable,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_index,
  output logic             changed
);

  // Terminal count: a mismatch seen while the counter sits here is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [COUNT-1:0] sync_1;
  logic [COUNT-1:0] sync_2;
  logic [COUNT-1:0] stable;
  logic [COUNT-1:0] stable_prev;
  logic [COUNT-1:0] press;
  logic [CNT_W-1:0] cnt [COUNT];

  logic             win_found;
  logic [COUNT-1:0] win_onehot;
  logic [COUNT-1:0] enable_next;
  logic             valid_next;
  logic [IDX_W-1:0] index_next;

  // Two-flop synchroniser per button; raw levels are asynchronous to the clock.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Per-channel debounce: a level change must persist DEBOUNCE_CYCLES cycles to be
  // accepted; any return to the accepted level throws away the partial count.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < COUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (sync_2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced level, used to spot 0->1 transitions of stable.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev <= '0;
    end else begin
      stable_prev <= stable;
    end
  end

  // A press is a rising edge of the debounced level; releases and holds are silent.
  assign press = stable & ~stable_prev;

  // Lowest-index press wins; everything else pressed in the same cycle is dropped.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (press[i] && !win_found) begin
        win_found     = 1'b1;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next selection: pressing the active source turns it off, any other replaces it.
  always_comb begin
    enable_next = enable;
    if (win_found) begin
      if ((enable & win_onehot) != '0) begin
        enable_next = '0;
      end else begin
        enable_next = win_onehot;
      end
    end
    valid_next = |enable_next;
    index_next = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (enable_next[i]) begin
        index_next = IDX_W'(i);
      end
    end
  end

  // Registered outputs; sel_valid and sel_index are derived from the same next value
  // as enable so the three always agree.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= '0;
      sel_valid <= 1'b0;
      sel_index <= '0;
      changed   <= 1'b0;
    end else begin
      enable    <= enable_next;
      sel_valid <= valid_next;
      sel_index <= index_next;
      changed   <= win_found;
    end
  end

endmodule
